// File: rtl/fp_addsub_ctrl.sv
// Sequencer for one single-precision add/subtract through the shared 24-bit
// sign-magnitude mantissa ALU: unpack, serial align, execute, serial normalise, pack.
module fp_addsub_ctrl #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [EXP_WIDTH+MAN_WIDTH-1:0] op_a,
    input  logic [EXP_WIDTH+MAN_WIDTH-1:0] op_b,
    input  logic                      symbol,
    output logic                      busy,
    output logic                      done,
    output logic [EXP_WIDTH+MAN_WIDTH-1:0] result,
    output logic [MAN_WIDTH-1:0]      alu_a,
    output logic [MAN_WIDTH-1:0]      alu_b,
    output logic                      alu_sign_a,
    output logic                      alu_sign_b,
    output logic                      alu_symbol,
    input  logic [MAN_WIDTH:0]        alu_out,
    input  logic                      alu_sign_out
);
    localparam int FW    = MAN_WIDTH - 1;
    localparam int SHCAP = MAN_WIDTH + 1;
    localparam logic [EXP_WIDTH-1:0] EMAX = '1;

    typedef struct packed {
        logic                 s;
        logic [EXP_WIDTH-1:0] e;
        logic [FW-1:0]        f;
    } fp_t;

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, EXEC, NORM, PACK} state_t;

    state_t               state;
    fp_t                  a_q, b_q;
    logic                 sym_q;
    logic [EXP_WIDTH-1:0] exp_r, d;
    logic                 shift_a, sign_r;
    logic [MAN_WIDTH:0]   m;
    logic                 nan_f, zero_f, ovf_f, udf_f;

    logic [EXP_WIDTH-1:0] d_full, d_cap;
    logic [MAN_WIDTH-1:0] ma, mb;

    // Denormals flush to a zero mantissa; the shift distance is capped since
    // a 24-bit mantissa is all zeros after 25 right shifts anyway.
    always_comb begin
        ma     = (a_q.e != '0) ? {1'b1, a_q.f} : '0;
        mb     = (b_q.e != '0) ? {1'b1, b_q.f} : '0;
        d_full = (a_q.e >= b_q.e) ? (a_q.e - b_q.e) : (b_q.e - a_q.e);
        d_cap  = (d_full > EXP_WIDTH'(SHCAP)) ? EXP_WIDTH'(SHCAP) : d_full;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sym_q      <= 1'b0;
            exp_r      <= '0;
            d          <= '0;
            shift_a    <= 1'b0;
            sign_r     <= 1'b0;
            m          <= '0;
            {nan_f, zero_f, ovf_f, udf_f} <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sign_a <= 1'b0;
            alu_sign_b <= 1'b0;
            alu_symbol <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a_q   <= op_a;
                    b_q   <= op_b;
                    sym_q <= symbol;
                    busy  <= 1'b1;
                    {nan_f, zero_f, ovf_f, udf_f} <= '0;
                    state <= UNPACK;
                end
                UNPACK: begin
                    exp_r      <= (a_q.e >= b_q.e) ? a_q.e : b_q.e;
                    shift_a    <= (a_q.e < b_q.e);
                    d          <= d_cap;
                    alu_a      <= ma;
                    alu_b      <= mb;
                    alu_sign_a <= a_q.s;
                    alu_sign_b <= b_q.s;
                    alu_symbol <= sym_q;
                    if (a_q.e == EMAX || b_q.e == EMAX) begin
                        nan_f <= 1'b1;
                        state <= PACK;
                    end else if (d_cap == '0) begin
                        state <= EXEC;
                    end else begin
                        state <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (shift_a) alu_a <= alu_a >> 1;
                    else         alu_b <= alu_b >> 1;
                    d <= d - 1'b1;
                    if (d == EXP_WIDTH'(1)) state <= EXEC;
                end
                EXEC: begin
                    m      <= alu_out;
                    sign_r <= alu_sign_out;
                    state  <= NORM;
                end
                NORM: begin
                    if (m == '0) begin
                        zero_f <= 1'b1;
                        state  <= PACK;
                    end else if (m[MAN_WIDTH]) begin
                        m     <= m >> 1;
                        exp_r <= exp_r + 1'b1;
                        if (exp_r == EMAX - 1'b1) begin
                            ovf_f <= 1'b1;
                            state <= PACK;
                        end
                    end else if (!m[MAN_WIDTH-1]) begin
                        m     <= m << 1;
                        exp_r <= exp_r - 1'b1;
                        if (exp_r == EXP_WIDTH'(1)) begin
                            udf_f <= 1'b1;
                            state <= PACK;
                        end
                    end else begin
                        state <= PACK;
                    end
                end
                PACK: begin
                    if (nan_f)       result <= {1'b0, EMAX, 1'b1, {(FW-1){1'b0}}};
                    else if (zero_f) result <= '0;
                    else if (ovf_f)  result <= {sign_r, EMAX, {FW{1'b0}}};
                    else if (udf_f)  result <= {sign_r, {(EXP_WIDTH+FW){1'b0}}};
                    else             result <= {sign_r, exp_r, m[FW-1:0]};
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
